// File: rtl/sr_flipflop_checker_if.sv
// Signal bundle between an SR flip-flop test harness (master) and the checker (slave).
// All signals are level-sampled on the rising clock edge; there is no handshake.
interface sr_flipflop_checker_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             s;
    logic             r;
    logic             q;
    logic             q_bar;
    logic             pass;
    logic             fail;
    logic             invalid;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] inv_cnt;
    logic [CNT_W-1:0] chk_cnt;
    logic [1:0]       state;

    modport master (
        output en, s, r, q, q_bar,
        input  pass, fail, invalid, err_cnt, inv_cnt, chk_cnt, state
    );

    modport slave (
        input  en, s, r, q, q_bar,
        output pass, fail, invalid, err_cnt, inv_cnt, chk_cnt, state
    );
endinterface

// File: rtl/sr_flipflop_checker.sv
// Hardware checker for a clocked SR flip-flop: keeps a reference model, compares Q/QBar
// every tracked cycle, flags S=R=1 and keeps saturating error/forbidden/check counters.
module sr_flipflop_checker #(
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                rst_n,
    sr_flipflop_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic             model;
    logic             fail;
    logic             invalid;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] inv_cnt;
    logic [CNT_W-1:0] chk_cnt;
    logic             forbidden;
    logic             mismatch;

    assign forbidden = bus.en && bus.s && bus.r;
    assign mismatch  = (bus.q != model) || (bus.q_bar == bus.q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            model   <= 1'b0;
            fail    <= 1'b0;
            invalid <= 1'b0;
            err_cnt <= '0;
            inv_cnt <= '0;
            chk_cnt <= '0;
        end else begin
            invalid <= 1'b0;
            if (state != IDLE && forbidden) begin
                invalid <= 1'b1;
                if (inv_cnt != CNT_MAX) inv_cnt <= inv_cnt + CNT_ONE;
            end
            // The comparison uses the model built from the previous edge's S/R,
            // so it happens even when En drops or S=R=1 arrives at this edge.
            if (state == TRACK) begin
                if (chk_cnt != CNT_MAX) chk_cnt <= chk_cnt + CNT_ONE;
                if (mismatch) begin
                    fail <= 1'b1;
                    if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
                end
            end
            case (state)
                IDLE: begin
                    if (bus.en) state <= SYNC;
                end
                SYNC: begin
                    if (!bus.en) begin
                        state <= IDLE;
                    end else if (bus.s != bus.r) begin
                        model <= bus.s;
                        state <= TRACK;
                    end
                end
                TRACK: begin
                    if (!bus.en) begin
                        state <= IDLE;
                    end else if (bus.s && bus.r) begin
                        state <= SYNC;
                    end else if (bus.s != bus.r) begin
                        model <= bus.s;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pass    = (state == TRACK) && (err_cnt == '0) && (inv_cnt == '0);
    assign bus.fail    = fail;
    assign bus.invalid = invalid;
    assign bus.err_cnt = err_cnt;
    assign bus.inv_cnt = inv_cnt;
    assign bus.chk_cnt = chk_cnt;
    assign bus.state   = state;
endmodule

// File: tb/tb_sr_flipflop_checker.sv
// Randomised bench for sr_flipflop_checker: an emulated flip-flop with injectable faults
// drives two checkers (8-bit and 2-bit counters) that are scored against a behavioural model.
module tb_sr_flipflop_checker;
    localparam int PW = 38;

    logic clk;
    logic rst_n;

    sr_flipflop_checker_if #(.CNT_W(8)) bus ();
    sr_flipflop_checker_if #(.CNT_W(2)) bus_s ();

    sr_flipflop_checker #(.CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    sr_flipflop_checker #(.CNT_W(2)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    logic [PW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // behavioural model: on = checking enabled, known = flip-flop value known
    bit m_on, m_known, m_val, m_fail, m_invalid;
    int c_err, c_inv, c_chk;

    // emulated flip-flop and fault knobs
    logic ff_q = 1'b0;
    logic stuck0 = 1'b0;
    logic qbar_eq = 1'b0;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    function automatic logic [7:0] sat8(input int n);
        return (n > 255) ? 8'hFF : n[7:0];
    endfunction

    function automatic logic [1:0] sat2(input int n);
        return (n > 3) ? 2'd3 : n[1:0];
    endfunction

    function automatic logic [PW-1:0] pack_exp();
        logic [1:0] st;
        logic p;
        st = !m_on ? 2'd0 : (m_known ? 2'd2 : 2'd1);
        p  = m_on && m_known && (c_err == 0) && (c_inv == 0);
        return {st, p, m_fail, m_invalid, sat8(c_err), sat8(c_inv), sat8(c_chk),
                p, m_fail, m_invalid, sat2(c_err), sat2(c_inv), sat2(c_chk)};
    endfunction

    function automatic logic [PW-1:0] pack_obs();
        return {bus.state, bus.pass, bus.fail, bus.invalid, bus.err_cnt, bus.inv_cnt, bus.chk_cnt,
                bus_s.pass, bus_s.fail, bus_s.invalid, bus_s.err_cnt, bus_s.inv_cnt, bus_s.chk_cnt};
    endfunction

    task automatic check(input logic [PW-1:0] expv, input string name);
        logic [PW-1:0] got;
        got = pack_obs();
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, expv);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_known = 0; m_val = 0; m_fail = 0; m_invalid = 0;
        c_err = 0; c_inv = 0; c_chk = 0;
    endtask

    task automatic model_edge(input logic e, input logic sv, input logic rv,
                              input logic qv, input logic qbv);
        m_invalid = 0;
        if (m_on && m_known) begin
            c_chk++;
            if (qv != m_val || qbv == qv) begin
                c_err++;
                m_fail = 1;
            end
        end
        if (m_on && e && sv && rv) begin
            c_inv++;
            m_invalid = 1;
        end
        if (!e) begin
            m_on = 0; m_known = 0;
        end else if (!m_on) begin
            m_on = 1;
        end else if (sv != rv) begin
            m_known = 1; m_val = sv;
        end else if (sv) begin
            m_known = 0;
        end
    endtask

    task automatic step(input logic e, input logic sv, input logic rv);
        logic qd, qbd;
        qd  = stuck0 ? 1'b0 : ff_q;
        qbd = qbar_eq ? qd : ~qd;
        bus.en = e; bus.s = sv; bus.r = rv; bus.q = qd; bus.q_bar = qbd;
        bus_s.en = e; bus_s.s = sv; bus_s.r = rv; bus_s.q = qd; bus_s.q_bar = qbd;
        @(posedge clk);
        model_edge(e, sv, rv, qd, qbd);
        exp_q.push_back(pack_exp());
        if (sv && !rv) ff_q = 1'b1;
        else if (!sv && rv) ff_q = 1'b0;
        #1;
    endtask

    // asynchronous reset between edges; outputs must already be cleared before the next edge
    task automatic reset_pulse();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #2;
        check(pack_exp(), "async_reset");
        #2;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check(exp_q.pop_front(), "scoreboard");
    end

    initial begin
        bus.en = 0; bus.s = 0; bus.r = 0; bus.q = 0; bus.q_bar = 1;
        bus_s.en = 0; bus_s.s = 0; bus_s.r = 0; bus_s.q = 0; bus_s.q_bar = 1;
        rst_n = 1'b1;
        reset_pulse();

        // directed: clean flip-flop, 14 comparisons after SYNC
        step(1, 0, 0);
        repeat (5) step(1, 1, 0);
        repeat (5) step(1, 0, 1);
        repeat (5) step(1, 0, 0);

        // Q stuck at 0 while setting: first compare matches, next three miss
        stuck0 = 1;
        repeat (4) step(1, 1, 0);
        stuck0 = 0;

        // forbidden input held for 3 edges, then resync
        repeat (3) step(1, 1, 1);
        step(1, 1, 0);
        step(1, 0, 0);

        // complementary output broken for one cycle
        qbar_eq = 1;
        step(1, 0, 0);
        qbar_eq = 0;
        step(1, 0, 0);

        // many mismatches: 2-bit counters saturate; En drops on a mismatch edge
        stuck0 = 1;
        repeat (6) step(1, 1, 0);
        step(0, 1, 0);
        stuck0 = 0;
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 0, 0);

        // reset mid-TRACK clears sticky state; re-enable goes through SYNC
        reset_pulse();
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 0);

        for (int i = 0; i < 800; i++) begin
            logic e, sv, rv;
            stuck0  = ($urandom_range(0, 15) == 0);
            qbar_eq = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 15) != 0);
            sv = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            step(e, sv, rv);
            if ($urandom_range(0, 249) == 0) reset_pulse();
        end
        stuck0 = 0;
        qbar_eq = 0;

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sr_flipflop_checker.md
# sr_flipflop_checker

Synthesizable monitor that sits beside a clocked SR flip-flop and consumes its S/R stimulus and Q/QBar response. It keeps a cycle-accurate reference model of the flip-flop, compares every sampled output against it, flags the forbidden S=R=1 input, and counts checks, mismatches and forbidden events. It is the checking end of the SR flip-flop interface: the stimulus source drives S/R, the flip-flop responds, and this block judges the response in hardware so lab boards can report pass/fail on LEDs.

## Interface
- CNT_W, 8: width of every event counter; counters saturate at 2^CNT_W-1.
- Clk  input  1  same clock as the monitored flip-flop; all state updates on rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- En  input  1  checking enable; low forces IDLE on the next edge.
- S  input  1  set input as driven to the flip-flop.
- R  input  1  reset input as driven to the flip-flop.
- Q  input  1  flip-flop output.
- QBar  input  1  flip-flop complementary output.
- Pass  output  1  high while in TRACK with ErrCnt==0 and InvCnt==0.
- Fail  output  1  sticky; set on first mismatch, cleared only by reset.
- Invalid  output  1  one-cycle pulse, registered, when S=R=1 is sampled while En=1.
- ErrCnt  output  CNT_W  number of mismatch cycles.
- InvCnt  output  CNT_W  number of S=R=1 samples.
- ChkCnt  output  CNT_W  number of cycles in which a comparison was performed.

## Operation
- States: IDLE, SYNC, TRACK.
- IDLE: no comparisons. Go to SYNC when En=1.
- SYNC: the model value is unknown. If S=1,R=0, load model=1 and go to TRACK. If S=0,R=1, load model=0 and go to TRACK. If S=0,R=0, stay in SYNC. If S=1,R=1, stay in SYNC and pulse Invalid.
- TRACK: each edge first compares the current Q/QBar with the model, then updates the model from the current S/R.
  - S=1,R=0: model becomes 1.
  - S=0,R=1: model becomes 0.
  - S=0,R=0: model holds.
  - S=1,R=1: pulse Invalid, increment InvCnt, go to SYNC. No comparison is made for the cycle after the forbidden input.
- Mismatch: Q≠model or QBar≠~Q. It increments ErrCnt and sets Fail. ChkCnt increments on every TRACK-state comparison.
- En=0 in any state: go to IDLE on the next edge. Counters and Fail hold. Re-enabling enters SYNC and does not clear the counters.
- Counters saturate and do not wrap.
- Pass is combinational from the registered state and counters.

## Timing
- Reset (Rst_n low, async):
  - state=IDLE, model=0.
  - Pass=0, Fail=0, Invalid=0, ErrCnt=0, InvCnt=0, ChkCnt=0.
- Deassertion of Rst_n takes effect at the first rising Clk edge after release.
- Flip-flop latency model: S/R sampled at edge k determine the Q expected at edge k+1. Q is therefore compared one edge after the S/R that produced it.
- SYNC to TRACK takes one edge. The first comparison happens at the next edge.
- Invalid asserts in the cycle after the edge that sampled S=R=1. It lasts exactly one cycle per sampled occurrence. S=R=1 held for n edges gives n pulses and InvCnt+=n.
- Fail and ErrCnt update at the same edge that detects the mismatch, so both are visible one cycle after the offending Q is sampled.
- Simultaneous events:
  - En falling at the same edge as a mismatch: the comparison still counts.
  - S=R=1 at the same edge as a mismatch: both counters increment.
- Reset mid-TRACK aborts immediately and clears everything, including sticky Fail.

## Test plan
- Reset, then En=1 with a correct flip-flop. Drive S=1/R=0 ×5, S=0/R=1 ×5, S=0/R=0 ×5 at a 20 ns Clk. Required: TRACK is entered after 1 edge; ErrCnt=0, InvCnt=0, Pass=1, Fail=0; ChkCnt=14.
- Hold Q stuck at 0 and drive S=1/R=0 for 4 edges from TRACK with model=0. Required: the first mismatch edge sets Fail=1, ErrCnt=1; further mismatches give ErrCnt=3 (the first S=1 comparison matches); Pass=0.
- S=1/R=1 for 3 edges while in TRACK. Required: 3 Invalid pulses, InvCnt=3, state SYNC; no comparisons and ChkCnt unchanged until the next S≠R.
- QBar forced equal to Q for 1 cycle. Required: ErrCnt increments by 1 and Fail=1.
- With CNT_W=2, force 6 mismatches. Required: ErrCnt saturates at 3 and does not wrap.
- Assert Rst_n low asynchronously mid-TRACK with Fail=1 and ErrCnt=2. Required: all outputs read 0 before the next Clk edge; after release with En=1, the block re-enters SYNC.
